// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM encoding, default
// widths, and error-cause codes used when reporting failed accesses.
package mem_pkg;

  localparam int MEM_DATA_WIDTH = 16;
  localparam int MEM_ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  // Error-cause codes; the responder only reports a single MemError bit,
  // these codes exist so a requester can describe why an access failed.
  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_ALIGN = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;
  localparam logic [1:0] ERR_BOTH  = 2'd3;

  // Picks one cause when several apply; conflicting strobes win, then
  // misalignment, then range.
  function automatic logic [1:0] errCause(input logic misaligned,
                                          input logic outOfRange,
                                          input logic bothStrobes);
    logic [1:0] cause;
    cause = ERR_NONE;
    if (outOfRange)  cause = ERR_RANGE;
    if (misaligned)  cause = ERR_ALIGN;
    if (bothStrobes) cause = ERR_BOTH;
    return cause;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM. The read port is registered and only
// updates when a read is enabled, so its output doubles as a held read value.
module mem_array #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] index_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Array storage: contents survive reset on purpose.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[index_i] <= wdata_i;
    end
  end

  // Read register: cleared by reset, otherwise holds until the next enabled read.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem[index_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/memory_responder.sv
// Memory-side responder for the multicycle datapath. Accepts one word
// request at a time, waits a fixed number of cycles, then pulses MemReady
// (with MemError for bad requests) and commits or returns data.
module memory_responder
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH  = MEM_DATA_WIDTH,
  parameter int ADDR_WIDTH  = MEM_ADDR_WIDTH,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  MemReady,
  output logic                  MemError,
  output logic                  Busy
);

  // First byte address past the end of the array.
  localparam logic [ADDR_WIDTH:0] BYTE_LIMIT = (ADDR_WIDTH + 1)'(1) << (DEPTH_LOG2 + 1);
  // Counter preload so that WAIT lasts exactly WAIT_STATES cycles.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
  localparam bit NO_WAIT = (WAIT_STATES == 0);

  mem_state_e            state_q;
  logic [3:0]            waitCnt_q;
  logic [DEPTH_LOG2-1:0] index_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  isWrite_q;
  logic                  err_q;
  logic                  memReady_q;
  logic                  memError_q;
  logic                  busy_q;

  logic                  reqValid;
  logic                  reqErr;
  logic [DEPTH_LOG2-1:0] reqIndex;
  logic                  respFromIdle;
  logic                  respFromWait;
  logic                  ramRe_d;
  logic                  ramWe_d;
  logic [DEPTH_LOG2-1:0] ramIndex_d;

  // Request decode: validity, word index and error classification of the
  // inputs as they stand in IDLE.
  always_comb begin
    reqValid = MemRead | MemWrite;
    reqIndex = Address[DEPTH_LOG2:1];
    reqErr   = Address[0]
             | ({1'b0, Address} >= BYTE_LIMIT)
             | (MemRead & MemWrite);
  end

  // RAM control: reads fire on the edge that enters RESP so data is valid
  // alongside MemReady; writes fire on the edge that leaves RESP. The two
  // never coincide, so one shared index port is enough.
  always_comb begin
    respFromIdle = 1'b0;
    respFromWait = 1'b0;
    ramRe_d      = 1'b0;
    ramWe_d      = 1'b0;
    ramIndex_d   = index_q;
    if (state_q == IDLE) begin
      ramIndex_d   = reqIndex;
      respFromIdle = NO_WAIT && reqValid;
    end
    if (state_q == WAIT) begin
      respFromWait = (waitCnt_q == 4'd0);
    end
    if (!Reset) begin
      if (respFromIdle) begin
        ramRe_d = MemRead & ~reqErr;
      end
      if (respFromWait) begin
        ramRe_d = ~isWrite_q & ~err_q;
      end
      ramWe_d = (state_q == RESP) & isWrite_q & ~err_q;
    end
  end

  // Control FSM: latches the request, counts wait states and produces the
  // registered MemReady/MemError/Busy outputs.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= IDLE;
      waitCnt_q  <= '0;
      index_q    <= '0;
      wdata_q    <= '0;
      isWrite_q  <= 1'b0;
      err_q      <= 1'b0;
      memReady_q <= 1'b0;
      memError_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      memReady_q <= 1'b0;
      memError_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (reqValid) begin
            index_q   <= reqIndex;
            wdata_q   <= WriteData;
            isWrite_q <= MemWrite;
            err_q     <= reqErr;
            busy_q    <= 1'b1;
            if (NO_WAIT) begin
              state_q    <= RESP;
              memReady_q <= 1'b1;
              memError_q <= reqErr;
            end else begin
              waitCnt_q <= WAIT_LOAD;
              state_q   <= WAIT;
            end
          end
        end
        WAIT: begin
          if (waitCnt_q == 4'd0) begin
            state_q    <= RESP;
            memReady_q <= 1'b1;
            memError_q <= err_q;
          end else begin
            waitCnt_q <= waitCnt_q - 4'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  mem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk_i  (CLK),
    .reset_i(Reset),
    .we_i   (ramWe_d),
    .re_i   (ramRe_d),
    .index_i(ramIndex_d),
    .wdata_i(wdata_q),
    .rdata_o(ReadData)
  );

  assign MemReady = memReady_q;
  assign MemError = memError_q;
  assign Busy     = busy_q;

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: three instances with 1, 0 and 3 wait states
// share inputs, with strobes steered to one instance at a time. Expected
// results come from a word-array model of the memory.
module tb_memory_responder;
  import mem_pkg::*;

  logic        clk;
  logic        reset;
  logic        memRead;
  logic        memWrite;
  logic [15:0] address;
  logic [15:0] writeData;
  int          sel;

  logic [15:0] rData [3];
  logic        rdy   [3];
  logic        err   [3];
  logic        busy  [3];

  int checks;
  int failures;

  logic [15:0] modelMem   [3][1024];
  bit          modelKnown [3][1024];
  logic [15:0] modelRd    [3];
  bit          modelRdKnown [3];

  function automatic int wsOf(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    memory_responder #(
      .DATA_WIDTH (16),
      .ADDR_WIDTH (16),
      .DEPTH_LOG2 (10),
      .WAIT_STATES(wsOf(g))
    ) dut (
      .CLK      (clk),
      .Reset    (reset),
      .MemRead  (memRead && (sel == g)),
      .MemWrite (memWrite && (sel == g)),
      .Address  (address),
      .WriteData(writeData),
      .ReadData (rData[g]),
      .MemReady (rdy[g]),
      .MemError (err[g]),
      .Busy     (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  // Spec-level model of one access: decides the error outcome and what the
  // memory and the held read value become.
  function automatic void modelApply(input int k, input bit rd, input bit wr,
                                     input logic [15:0] a, input logic [15:0] d,
                                     output bit expErr);
    int byteAddr;
    int word;
    byteAddr = int'(a);
    word = byteAddr / 2;
    expErr = (byteAddr % 2 == 1) || (byteAddr >= 2048) || (rd && wr);
    if (!expErr && wr) begin
      modelMem[k][word]   = d;
      modelKnown[k][word] = 1'b1;
    end
    if (!expErr && rd) begin
      modelRd[k]      = modelMem[k][word];
      modelRdKnown[k] = modelKnown[k][word];
    end
  endfunction

  function automatic void modelReset();
    for (int k = 0; k < 3; k++) begin
      modelRd[k]      = 16'h0000;
      modelRdKnown[k] = 1'b1;
    end
  endfunction

  // Issues one request starting just after a negedge with the DUT idle;
  // returns latency in cycles from the accepting edge plus sampled outputs.
  task automatic doReq(input int k, input bit rd, input bit wr,
                       input logic [15:0] a, input logic [15:0] d,
                       output int lat, output bit errSeen, output logic [15:0] rdSeen);
    sel = k; memRead = rd; memWrite = wr; address = a; writeData = d;
    @(posedge clk);
    #1;
    memRead = 1'b0; memWrite = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (rdy[k] === 1'b1) break;
    end
    errSeen = err[k];
    rdSeen  = rData[k];
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; memRead = 1'b0; memWrite = 1'b0; address = '0; writeData = '0; sel = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({rdy[k], err[k], busy[k], rData[k]} !== 19'h0) begin
        failures++;
        $display("[TB] FAIL reset_outputs dut%0d: got %h required 0", k, {rdy[k], err[k], busy[k], rData[k]});
      end
    end
    reset = 1'b0;
    modelReset();
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int lat; bit e; logic [15:0] r; bit expErr;
    doReq(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, lat, e, r);
    modelApply(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, expErr);
    checks++;
    if (lat !== 2) begin failures++; $display("[TB] FAIL wr_latency: got %0d required 2", lat); end
    checks++;
    if (e !== 1'b0) begin failures++; $display("[TB] FAIL wr_error: got %0b required 0", e); end
    doReq(0, 1'b1, 1'b0, 16'h0010, 16'h0000, lat, e, r);
    modelApply(0, 1'b1, 1'b0, 16'h0010, 16'h0000, expErr);
    checks++;
    if (lat !== 2) begin failures++; $display("[TB] FAIL rd_latency: got %0d required 2", lat); end
    checks++;
    if (e !== 1'b0) begin failures++; $display("[TB] FAIL rd_error: got %0b required 0", e); end
    checks++;
    if (r !== 16'hBEEF) begin failures++; $display("[TB] FAIL rd_data: got %h required beef", r); end
  endtask

  task automatic test_errors();
    int lat; bit e; logic [15:0] r; bit expErr;
    doReq(0, 1'b0, 1'b1, 16'h0000, 16'h5A5A, lat, e, r);
    modelApply(0, 1'b0, 1'b1, 16'h0000, 16'h5A5A, expErr);
    doReq(0, 1'b1, 1'b0, 16'h0000, 16'h0000, lat, e, r);
    modelApply(0, 1'b1, 1'b0, 16'h0000, 16'h0000, expErr);
    doReq(0, 1'b1, 1'b0, 16'h0011, 16'h0000, lat, e, r);
    modelApply(0, 1'b1, 1'b0, 16'h0011, 16'h0000, expErr);
    checks++;
    if (e !== 1'b1 || lat !== 2) begin failures++; $display("[TB] FAIL misalign_err: got err=%0b lat=%0d required err=1 lat=2", e, lat); end
    checks++;
    if (r !== modelRd[0]) begin failures++; $display("[TB] FAIL misalign_hold: got %h required %h", r, modelRd[0]); end
    doReq(0, 1'b0, 1'b1, 16'h0800, 16'hDEAD, lat, e, r);
    modelApply(0, 1'b0, 1'b1, 16'h0800, 16'hDEAD, expErr);
    checks++;
    if (e !== 1'b1) begin failures++; $display("[TB] FAIL range_err: got %0b required 1", e); end
    doReq(0, 1'b1, 1'b0, 16'h0000, 16'h0000, lat, e, r);
    modelApply(0, 1'b1, 1'b0, 16'h0000, 16'h0000, expErr);
    checks++;
    if (r !== 16'h5A5A) begin failures++; $display("[TB] FAIL range_no_write: got %h required 5a5a", r); end
    doReq(0, 1'b0, 1'b1, 16'h0020, 16'h7777, lat, e, r);
    modelApply(0, 1'b0, 1'b1, 16'h0020, 16'h7777, expErr);
    doReq(0, 1'b1, 1'b1, 16'h0020, 16'h1234, lat, e, r);
    modelApply(0, 1'b1, 1'b1, 16'h0020, 16'h1234, expErr);
    checks++;
    if (e !== 1'b1) begin failures++; $display("[TB] FAIL both_err: got %0b required 1", e); end
    doReq(0, 1'b1, 1'b0, 16'h0020, 16'h0000, lat, e, r);
    modelApply(0, 1'b1, 1'b0, 16'h0020, 16'h0000, expErr);
    checks++;
    if (r !== 16'h7777) begin failures++; $display("[TB] FAIL both_no_write: got %h required 7777", r); end
  endtask

  task automatic test_back_to_back();
    int lat; bit e; logic [15:0] r; bit expErr;
    bit expPulse [4];
    expPulse[0] = 1'b1; expPulse[1] = 1'b0; expPulse[2] = 1'b1; expPulse[3] = 1'b0;
    doReq(1, 1'b0, 1'b1, 16'h0000, 16'hC0DE, lat, e, r);
    modelApply(1, 1'b0, 1'b1, 16'h0000, 16'hC0DE, expErr);
    checks++;
    if (lat !== 1) begin failures++; $display("[TB] FAIL ws0_latency: got %0d required 1", lat); end
    sel = 1; memRead = 1'b1; memWrite = 1'b0; address = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (busy[1] !== expPulse[i] || rdy[1] !== expPulse[i]) begin
        failures++;
        $display("[TB] FAIL b2b_cycle%0d: got busy=%0b ready=%0b required %0b", i, busy[1], rdy[1], expPulse[i]);
      end
      if (expPulse[i]) begin
        checks++;
        if (rData[1] !== 16'hC0DE || err[1] !== 1'b0) begin
          failures++;
          $display("[TB] FAIL b2b_data%0d: got %h err=%0b required c0de err=0", i, rData[1], err[1]);
        end
      end
    end
    memRead = 1'b0;
    modelApply(1, 1'b1, 1'b0, 16'h0000, 16'h0000, expErr);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat; bit e; logic [15:0] r; bit expErr;
    int insts [2];
    insts[0] = 0; insts[1] = 2;
    foreach (insts[j]) begin
      int k;
      k = insts[j];
      doReq(k, 1'b0, 1'b1, 16'h0004, 16'h1111, lat, e, r);
      modelApply(k, 1'b0, 1'b1, 16'h0004, 16'h1111, expErr);
      sel = k; memWrite = 1'b1; address = 16'h0004; writeData = 16'hAAAA;
      @(posedge clk);
      #1;
      memWrite = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({rdy[k], err[k], busy[k], rData[k]} !== 19'h0) begin
        failures++;
        $display("[TB] FAIL reset_mid dut%0d: got %h required 0", k, {rdy[k], err[k], busy[k], rData[k]});
      end
      reset = 1'b0;
      modelReset();
      @(negedge clk);
      doReq(k, 1'b1, 1'b0, 16'h0004, 16'h0000, lat, e, r);
      modelApply(k, 1'b1, 1'b0, 16'h0004, 16'h0000, expErr);
      checks++;
      if (r !== 16'h1111 || lat !== wsOf(k) + 1) begin
        failures++;
        $display("[TB] FAIL reset_no_commit dut%0d: got %h lat=%0d required 1111 lat=%0d", k, r, lat, wsOf(k) + 1);
      end
    end
  endtask

  task automatic test_input_change();
    int lat; bit e; logic [15:0] r; bit expErr;
    doReq(2, 1'b0, 1'b1, 16'h0002, 16'h2222, lat, e, r);
    modelApply(2, 1'b0, 1'b1, 16'h0002, 16'h2222, expErr);
    doReq(2, 1'b0, 1'b1, 16'h0006, 16'h6666, lat, e, r);
    modelApply(2, 1'b0, 1'b1, 16'h0006, 16'h6666, expErr);
    sel = 2; memRead = 1'b1; memWrite = 1'b0; address = 16'h0002;
    @(posedge clk);
    #1;
    address = 16'h0006; memWrite = 1'b1; writeData = 16'hFFFF;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (rdy[2] === 1'b1) break;
    end
    memRead = 1'b0; memWrite = 1'b0;
    modelApply(2, 1'b1, 1'b0, 16'h0002, 16'h0000, expErr);
    checks++;
    if (lat !== 4 || rData[2] !== 16'h2222 || err[2] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL input_change: got lat=%0d data=%h err=%0b required lat=4 data=2222 err=0", lat, rData[2], err[2]);
    end
    @(negedge clk);
    doReq(2, 1'b1, 1'b0, 16'h0006, 16'h0000, lat, e, r);
    modelApply(2, 1'b1, 1'b0, 16'h0006, 16'h0000, expErr);
    checks++;
    if (r !== 16'h6666) begin failures++; $display("[TB] FAIL input_change_untouched: got %h required 6666", r); end
  endtask

  task automatic test_random();
    int lat; bit e; logic [15:0] r; bit expErr;
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < 16; w++) begin
        logic [15:0] d;
        d = 16'($urandom);
        doReq(k, 1'b0, 1'b1, 16'(w * 2), d, lat, e, r);
        modelApply(k, 1'b0, 1'b1, 16'(w * 2), d, expErr);
      end
      for (int n = 0; n < 30; n++) begin
        int mode; int word; bit rd; bit wr; logic [15:0] a; logic [15:0] d;
        mode = int'($urandom_range(0, 9));
        word = int'($urandom_range(0, 15));
        rd = ($urandom_range(0, 1) == 0);
        wr = !rd;
        a = 16'(word * 2);
        d = 16'($urandom);
        if (mode == 0) a = a | 16'h0001;
        if (mode == 1) a = a + 16'h0800 + 16'(int'($urandom_range(0, 20)) * 2048);
        if (mode == 2) begin rd = 1'b1; wr = 1'b1; end
        doReq(k, rd, wr, a, d, lat, e, r);
        modelApply(k, rd, wr, a, d, expErr);
        checks++;
        if (lat !== wsOf(k) + 1 || e !== expErr) begin
          failures++;
          $display("[TB] FAIL rand_resp dut%0d addr=%h cause=%0d: got lat=%0d err=%0b required lat=%0d err=%0b", k, a, errCause(a[0], a >= 16'h0800, rd && wr), lat, e, wsOf(k) + 1, expErr);
        end
        if (modelRdKnown[k]) begin
          checks++;
          if (r !== modelRd[k]) begin
            failures++;
            $display("[TB] FAIL rand_data dut%0d addr=%h rd=%0b wr=%0b: got %h required %h", k, a, rd, wr, r, modelRd[k]);
          end
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < 1024; w++) begin
        modelMem[k][w]   = 16'h0000;
        modelKnown[k][w] = 1'b0;
      end
    end
    @(negedge clk);
    test_reset();
    test_write_read();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_input_change();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
